// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - trace packet capture FIFO drained over a req/gnt/rvalid bus slave
// Packets enter on trace_valid_i; the host reads STATUS/CTRL/DATA words and pops on the last DATA word.
module trace_buffer #(
   parameter int TRACE_WIDTH   = 96,
   parameter int DEPTH         = 16,
   parameter int IRQ_THRESHOLD = 12,
   parameter int ADDR_WIDTH    = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   trace_valid_i,
   input  logic [TRACE_WIDTH-1:0] trace_data_i,
   input  logic                   req_i,
   input  logic [ADDR_WIDTH-1:0]  addr_i,
   input  logic                   we_i,
   input  logic [3:0]             be_i,
   input  logic [31:0]            wdata_i,
   output logic                   gnt_o,
   output logic                   rvalid_o,
   output logic [31:0]            rdata_o,
   output logic                   err_o,
   output logic                   irq_o
);

   localparam int WORDS = (TRACE_WIDTH + 31) / 32;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;

   logic [WORDS*32-1:0] mem [DEPTH];
   logic [WORDS*32-1:0] din;
   logic [WORDS*32-1:0] head;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic                overflow, enable;
   logic                full, empty;

   logic [5:0]          idx, word_sel;
   logic                is_status, is_ctrl, is_data;
   logic                ctrl_wr, clear, pop, push_try, push, ovf_set;
   logic [31:0]         status, rd_data;
   logic                rd_err;

   logic                unused_ok;
   assign unused_ok = &{1'b0, addr_i[ADDR_WIDTH-1:8], addr_i[1:0], be_i[3:1], wdata_i[31:2]};

   assign gnt_o = req_i;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   assign idx       = addr_i[7:2];
   assign word_sel  = idx - 6'd4;
   assign is_status = (idx == 6'd0);
   assign is_ctrl   = (idx == 6'd1);
   assign is_data   = (idx >= 6'd4) && ({1'b0, idx} < 7'(4 + WORDS));

   assign ctrl_wr  = req_i & we_i & is_ctrl & be_i[0];
   assign clear    = ctrl_wr & wdata_i[0];
   assign pop      = req_i & ~we_i & is_data & (word_sel == 6'(WORDS - 1)) & ~empty;
   // A clear in the same cycle discards the incoming packet without flagging overflow.
   assign push_try = trace_valid_i & enable & ~clear;
   assign push     = push_try & (~full | pop);
   assign ovf_set  = push_try & full & ~pop;

   always_comb begin
      din = '0;
      din[TRACE_WIDTH-1:0] = trace_data_i;
   end

   always_comb begin
      status = '0;
      status[CW-1:0] = count;
      status[16] = empty;
      status[17] = full;
      status[18] = overflow;
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (is_status) begin
         if (!we_i) rd_data = status;
      end else if (is_ctrl) begin
         if (!we_i) rd_data = {30'b0, enable, 1'b0};
      end else if (is_data) begin
         if (!we_i && !empty) begin
            for (int k = 0; k < WORDS; k++) begin
               if (word_sel == k[5:0]) rd_data = head[k*32 +: 32];
            end
         end
      end else begin
         rd_err = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         enable   <= 1'b1;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
         irq_o    <= 1'b0;
      end else begin
         rvalid_o <= req_i;
         if (req_i) begin
            rdata_o <= rd_data;
            err_o   <= rd_err;
         end
         irq_o <= (count >= CW'(IRQ_THRESHOLD)) | overflow;
         if (ctrl_wr) enable <= wdata_i[1];
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (ovf_set) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - scoreboard bench for trace_buffer
// Requests push expected responses; a negedge monitor pops and compares on rvalid_o.
module tb_trace_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tv = 1'b0;
   logic [95:0] td = '0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        gnt, rvalid, err, irq;
   logic [31:0] rdata;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   trace_buffer dut (
      .clk_i(clk), .rst_i(rst), .trace_valid_i(tv), .trace_data_i(td),
      .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .irq_o(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (req) begin
         total++;
         if (gnt !== 1'b1) begin
            bad++;
            $display("FAIL gnt: got %b expected 1", gnt);
         end
      end
      if (rvalid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rvalid: got rdata=%h err=%b expected no response", rdata, err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (rdata !== e.data || err !== e.err || cyc != e.cyc) begin
               bad++;
               $display("FAIL %s: got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                        e.name, rdata, err, cyc, e.data, e.err, e.cyc);
            end
         end
      end
   end

   function automatic logic [31:0] word(input int n, input int k);
      return 32'h1000_0000 * 32'(k + 1) + 32'(n);
   endfunction

   function automatic logic [95:0] pkt(input int n);
      return {word(n, 2), word(n, 1), word(n, 0)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                      input logic [31:0] exp_d, input logic exp_e, input logic push_tv,
                      input logic [95:0] push_td, input string nm);
      exp_t e;
      req = 1'b1; we = w; addr = a; wdata = wd; be = b; tv = push_tv; td = push_td;
      e.data = exp_d; e.err = exp_e; e.cyc = cyc + 1; e.name = nm;
      exp_q.push_back(e);
      step();
      req = 1'b0; we = 1'b0; tv = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e, input string nm);
      bus(1'b0, a, 32'h0, 4'h0, exp_d, exp_e, 1'b0, '0, nm);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                     input logic exp_e, input string nm);
      bus(1'b1, a, wd, b, 32'h0, exp_e, 1'b0, '0, nm);
   endtask

   task automatic push_pkt(input int n);
      tv = 1'b1; td = pkt(n);
      step();
      tv = 1'b0;
   endtask

   task automatic read_pkt(input int n);
      rd(32'h10, word(n, 0), 1'b0, $sformatf("pkt%0d_w0", n));
      rd(32'h14, word(n, 1), 1'b0, $sformatf("pkt%0d_w1", n));
      rd(32'h18, word(n, 2), 1'b0, $sformatf("pkt%0d_w2", n));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      step();
      step();
      @(negedge clk);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_gnt_idle", 32'(gnt), 32'h0);
      step();
      rst = 1'b0;
      rd(32'h00, 32'h0001_0000, 1'b0, "rst_status");
      rd(32'h04, 32'h0000_0002, 1'b0, "rst_ctrl");

      // 1: three packets in order
      for (int i = 1; i <= 3; i++) push_pkt(i);
      rd(32'h00, 32'h0000_0003, 1'b0, "t1_status3");
      for (int i = 1; i <= 3; i++) read_pkt(i);
      rd(32'h00, 32'h0001_0000, 1'b0, "t1_status_empty");

      // 2: overflow with 17 packets
      for (int i = 100; i <= 116; i++) push_pkt(i);
      rd(32'h00, 32'h0006_0010, 1'b0, "t2_status_full_ovf");
      @(negedge clk);
      chk("t2_irq_set", 32'(irq), 32'h1);
      step();
      for (int i = 100; i <= 115; i++) read_pkt(i);
      rd(32'h00, 32'h0005_0000, 1'b0, "t2_status_drained");
      wr(32'h04, 32'h3, 4'hF, 1'b0, "t2_clear");
      rd(32'h00, 32'h0001_0000, 1'b0, "t2_status_cleared");
      @(negedge clk);
      chk("t2_irq_clr", 32'(irq), 32'h0);
      step();

      // 3: push and pop together while full
      for (int i = 200; i <= 215; i++) push_pkt(i);
      rd(32'h10, word(200, 0), 1'b0, "t3_w0");
      rd(32'h14, word(200, 1), 1'b0, "t3_w1");
      bus(1'b0, 32'h18, 32'h0, 4'h0, word(200, 2), 1'b0, 1'b1, pkt(216), "t3_w2_pushpop");
      rd(32'h00, 32'h0002_0010, 1'b0, "t3_status_full_noovf");
      for (int i = 201; i <= 216; i++) read_pkt(i);
      rd(32'h00, 32'h0001_0000, 1'b0, "t3_status_empty");

      // 4: clear versus push, byte enable gating
      push_pkt(300);
      push_pkt(301);
      rd(32'h00, 32'h0000_0002, 1'b0, "t4_status2");
      bus(1'b1, 32'h04, 32'h1, 4'hF, 32'h0, 1'b0, 1'b1, pkt(302), "t4_clear_push");
      rd(32'h00, 32'h0001_0000, 1'b0, "t4_status_cleared");
      rd(32'h04, 32'h0000_0000, 1'b0, "t4_ctrl_disabled");
      push_pkt(303);
      rd(32'h00, 32'h0001_0000, 1'b0, "t4_status_disabled_drop");
      wr(32'h04, 32'h2, 4'hF, 1'b0, "t4_enable");
      rd(32'h04, 32'h0000_0002, 1'b0, "t4_ctrl_enabled");
      push_pkt(304);
      wr(32'h04, 32'h1, 4'h0, 1'b0, "t4_ctrl_be0");
      rd(32'h00, 32'h0000_0001, 1'b0, "t4_status_be0");
      rd(32'h04, 32'h0000_0002, 1'b0, "t4_ctrl_be0");
      read_pkt(304);

      // 5: unmapped and empty accesses
      rd(32'h08, 32'h0, 1'b1, "t5_unmapped_08");
      rd(32'h0C, 32'h0, 1'b1, "t5_unmapped_0c");
      rd(32'h1C, 32'h0, 1'b1, "t5_unmapped_1c");
      rd(32'h10, 32'h0, 1'b0, "t5_empty_w0");
      rd(32'h18, 32'h0, 1'b0, "t5_empty_w2");
      wr(32'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, "t5_wr_status");
      wr(32'h08, 32'hFFFF_FFFF, 4'hF, 1'b1, "t5_wr_unmapped");
      rd(32'h00, 32'h0001_0000, 1'b0, "t5_status");

      // 6: reset with entries and a read in flight
      for (int i = 400; i <= 412; i++) push_pkt(i);
      wr(32'h04, 32'h0, 4'h1, 1'b0, "t6_disable");
      @(negedge clk);
      chk("t6_irq_before", 32'(irq), 32'h1);
      step();
      req = 1'b1; we = 1'b0; addr = 32'h0; rst = 1'b1;
      step();
      req = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("t6_rvalid_dropped", 32'(rvalid), 32'h0);
      chk("t6_irq_reset", 32'(irq), 32'h0);
      step();
      rd(32'h00, 32'h0001_0000, 1'b0, "t6_status");
      rd(32'h04, 32'h0000_0002, 1'b0, "t6_ctrl_enable");

      step();
      step();
      step();
      chk("pending_responses", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
